chan_carry_eval: RTL and testbench

Parametrised, pipelined successor to the mapped per-channel select/carry evaluator. Each of CH channels chooses a pattern bit by its select line and classifies itself as generate, kill or propagate. A ripple carry then resolves across the channels from a carry-in. The block adds a two-stage valid/ready pipeline with backpressure and optional hit statistics, and sits between the pattern-decode front end and the result collector.

---
 rtl/chan_carry_eval.sv | 156 +++++++++++++++
 tb/tb_chan_carry_eval.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_carry_eval.sv
// chan_carry_eval: per-channel pattern select with generate/kill/propagate
// classification and a ripple carry across channels, wrapped in a two-stage
// valid/ready pipeline with backpressure.
// Optional feature macro: CHAN_CARRY_STATS_EN builds the saturating hit_cnt
// counter and honours cnt_clr; otherwise hit_cnt is tied to zero.
module chan_carry_eval #(
  parameter int unsigned CH    = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH-1:0]    dat,
  input  logic [CH-1:0]    sel,
  input  logic             hi0,
  input  logic             hi1,
  input  logic             lo0,
  input  logic             lo1,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH-1:0]    hit,
  output logic             carry_out,
  output logic             any_gen,
  output logic             all_hit,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             cnt_clr
);

  // Front-end classification of the incoming beat
  logic [CH-1:0] ph;
  logic [CH-1:0] pl;
  logic [CH-1:0] gen;
  logic [CH-1:0] kill;

  // Handshake
  logic accept;
  logic s2_load;

  // Stage 1 state
  logic          s1_valid_q;
  logic [CH-1:0] s1_g_q;
  logic [CH-1:0] s1_k_q;
  logic          s1_cin_q;

  // Stage 2 state (result registers)
  logic          s2_valid_q;
  logic [CH-1:0] hit_q;
  logic          carry_q;
  logic          any_gen_q;
  logic          all_hit_q;

  // Stage 2 next-state values computed from stage 1
  logic [CH-1:0] hit_d;
  logic [CH:0]   chain;
  logic          carry_d;
  logic          any_gen_d;
  logic          all_hit_d;

  // Select the pattern bit per channel and classify as generate / kill
  always_comb begin
    ph   = (sel & {CH{hi1}}) | (~sel & {CH{hi0}});
    pl   = (sel & {CH{lo1}}) | (~sel & {CH{lo0}});
    gen  = dat & ph;
    kill = ~dat & ~pl;
  end

  // S2 can take a beat when empty or emptying this cycle; S1 follows S2.
  // in_ready depends on out_ready but never on in_valid.
  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;

  // Stage 1: capture classification on accept, drain when S2 takes the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_k_q     <= '0;
      s1_cin_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_g_q     <= gen;
      s1_k_q     <= kill;
      s1_cin_q   <= cin;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Resolve hits, ripple carry and summary flags from the stage 1 contents
  always_comb begin
    hit_d    = s1_g_q | s1_k_q;
    chain    = '0;
    chain[0] = s1_cin_q;
    for (int unsigned i = 0; i < CH; i++) begin
      chain[i+1] = s1_g_q[i] | (chain[i] & ~s1_k_q[i]);
    end
    carry_d   = chain[CH];
    any_gen_d = |s1_g_q;
    all_hit_d = &hit_d;
  end

  // Stage 2: result registers only change when a real beat moves in, so they
  // keep their last value while empty and stay stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      hit_q      <= '0;
      carry_q    <= 1'b0;
      any_gen_q  <= 1'b0;
      all_hit_q  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        hit_q     <= hit_d;
        carry_q   <= carry_d;
        any_gen_q <= any_gen_d;
        all_hit_q <= all_hit_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign hit       = hit_q;
  assign carry_out = carry_q;
  assign any_gen   = any_gen_q;
  assign all_hit   = all_hit_q;

`ifdef CHAN_CARRY_STATS_EN
  logic             deliver;
  logic [CNT_W-1:0] hit_cnt_q;

  assign deliver = s2_valid_q & out_ready;

  // Count delivered all-hit beats, saturating; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else if (cnt_clr) begin
      hit_cnt_q <= '0;
    end else if (deliver && all_hit_q && !(&hit_cnt_q)) begin
      hit_cnt_q <= hit_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt = hit_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_chan_carry_eval.sv
// Self-checking bench for chan_carry_eval: directed test-plan vectors,
// backpressure, randomized traffic against a reference model, statistics and
// asynchronous reset. Works with or without CHAN_CARRY_STATS_EN.
module tb_chan_carry_eval;

  localparam int unsigned CH      = 3;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef CHAN_CARRY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // {hit, carry_out, any_gen, all_hit}
  typedef logic [CH+2:0] res_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CH-1:0]    dat;
  logic [CH-1:0]    sel;
  logic             hi0, hi1, lo0, lo1;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [CH-1:0]    hit;
  logic             carry_out;
  logic             any_gen;
  logic             all_hit;
  logic [CNT_W-1:0] hit_cnt;
  logic             cnt_clr;

  res_t obs;
  assign obs = {hit, carry_out, any_gen, all_hit};

  int checks = 0;
  int fails  = 0;

  res_t        exp_q[$];
  int unsigned model_cnt;

  chan_carry_eval #(
    .CH    (CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dat       (dat),
    .sel       (sel),
    .hi0       (hi0),
    .hi1       (hi1),
    .lo0       (lo0),
    .lo1       (lo1),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hit       (hit),
    .carry_out (carry_out),
    .any_gen   (any_gen),
    .all_hit   (all_hit),
    .hit_cnt   (hit_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the carry out is decided by the highest channel that either
  // generates or kills; if none does, cin propagates straight through.
  function automatic res_t ref_model(input logic [CH-1:0] d, input logic [CH-1:0] s,
                                     input logic h0, input logic h1, input logic l0,
                                     input logic l1, input logic c);
    logic [CH-1:0] h;
    logic          anyg;
    logic          cy;
    logic          ph, pl, g, k;
    h    = '0;
    anyg = 1'b0;
    cy   = c;
    for (int i = 0; i < CH; i++) begin
      ph   = s[i] ? h1 : h0;
      pl   = s[i] ? l1 : l0;
      g    = d[i] & ph;
      k    = !d[i] && !pl;
      h[i] = g | k;
      if (g) anyg = 1'b1;
      if (g) cy = 1'b1;
      else if (k) cy = 1'b0;
    end
    return {h, cy, anyg, (h == {CH{1'b1}})};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    dat = '0; sel = '0; hi0 = 1'b0; hi1 = 1'b0; lo0 = 1'b0; lo1 = 1'b0; cin = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (obs !== '0) begin
      fails++; $display("FAIL reset_results: got %b want 0", obs);
    end
    checks++;
    if (hit_cnt !== '0) begin
      fails++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle_out_valid: got %b want 0", out_valid);
    end
  endtask

  // Test-plan vectors with hi0=1, hi1=0, lo0=0, lo1=1
  task automatic test_directed();
    logic [CH-1:0] td[4];
    logic [CH-1:0] ts[4];
    logic          tc[4];
    res_t          te[4];
    td[0] = 3'b111; ts[0] = 3'b000; tc[0] = 1'b0; te[0] = 6'b111_1_1_1; // full generate
    td[1] = 3'b000; ts[1] = 3'b111; tc[1] = 1'b1; te[1] = 6'b000_1_0_0; // propagate, cin=1
    td[2] = 3'b000; ts[2] = 3'b111; tc[2] = 1'b0; te[2] = 6'b000_0_0_0; // propagate, cin=0
    td[3] = 3'b001; ts[3] = 3'b000; tc[3] = 1'b0; te[3] = 6'b111_0_1_1; // kill over generate
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hi0 = 1'b1; hi1 = 1'b0; lo0 = 1'b0; lo1 = 1'b1;
      in_valid = 1'b1; dat = td[i]; sel = ts[i]; cin = tc[i]; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        fails++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        fails++; $display("FAIL dir_early_valid[%0d]: got %b want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || obs !== te[i]) begin
        fails++;
        $display("FAIL dir_result[%0d]: got valid=%b res=%b want valid=1 res=%b",
                 i, out_valid, obs, te[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL dir_drained: got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [CH-1:0] bd[4];
    logic [CH-1:0] bs[4];
    logic          bc[4];
    res_t          be[4];
    int            nacc;
    int            ndel;
    logic          rdy;
    @(negedge clk);
    hi0 = 1'($urandom_range(0, 1)); hi1 = 1'($urandom_range(0, 1));
    lo0 = 1'($urandom_range(0, 1)); lo1 = 1'($urandom_range(0, 1));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bd[i] = CH'($urandom()); bs[i] = CH'($urandom()); bc[i] = 1'($urandom_range(0, 1));
      be[i] = ref_model(bd[i], bs[i], hi0, hi1, lo0, lo1, bc[i]);
    end
    nacc = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; dat = bd[nacc]; sel = bs[nacc]; cin = bc[nacc];
      #1;
      checks++;
      if (in_ready !== (nacc < 2)) begin
        fails++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, in_ready, (nacc < 2));
      end
      if (cyc >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== be[0]) begin
          fails++;
          $display("FAIL bp_hold[%0d]: got valid=%b res=%b want valid=1 res=%b",
                   cyc, out_valid, obs, be[0]);
        end
      end
      rdy = in_ready;
      @(posedge clk);
      if (rdy) nacc++;
    end
    checks++;
    if (nacc !== 2) begin
      fails++; $display("FAIL bp_accepts: got %0d want 2", nacc);
    end
    ndel = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (nacc < 4) begin
        in_valid = 1'b1; dat = bd[nacc]; sel = bs[nacc]; cin = bc[nacc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (out_valid !== 1'b1 || obs !== be[ndel]) begin
        fails++;
        $display("FAIL bp_order[%0d]: got valid=%b res=%b want valid=1 res=%b",
                 ndel, out_valid, obs, be[ndel]);
      end
      rdy = in_valid && in_ready;
      @(posedge clk);
      if (rdy) nacc++;
      ndel++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || nacc !== 4) begin
      fails++; $display("FAIL bp_empty: got valid=%b accepts=%0d want valid=0 accepts=4",
                        out_valid, nacc);
    end
  endtask

  task automatic test_random();
    logic             prev_gap;
    logic             acc;
    logic             del;
    res_t             front;
    logic [CNT_W-1:0] exp_cnt;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    model_cnt = 0;
    exp_q.delete();
    prev_gap = 1'b0;
    front = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cnt_clr   = ($urandom_range(0, 24) == 0);
      dat = CH'($urandom()); sel = CH'($urandom());
      hi0 = 1'($urandom_range(0, 1)); hi1 = 1'($urandom_range(0, 1));
      lo0 = 1'($urandom_range(0, 1)); lo1 = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (in_ready !== !(exp_q.size() == 2 && !out_ready)) begin
        fails++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, in_ready,
                          !(exp_q.size() == 2 && !out_ready));
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rnd_spurious[%0d]: got valid=1 want valid=0", cyc);
        end else if (obs !== exp_q[0]) begin
          fails++; $display("FAIL rnd_data[%0d]: got %b want %b", cyc, obs, exp_q[0]);
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        if (prev_gap) begin
          fails++; $display("FAIL rnd_bubble[%0d]: got valid=0 twice want valid=1", cyc);
        end
      end
      prev_gap = !out_valid && exp_q.size() != 0;
      exp_cnt = STATS ? CNT_W'(model_cnt) : '0;
      checks++;
      if (hit_cnt !== exp_cnt) begin
        fails++; $display("FAIL rnd_hit_cnt[%0d]: got %0d want %0d", cyc, hit_cnt, exp_cnt);
      end
      del = out_valid && out_ready && exp_q.size() != 0;
      acc = in_valid && in_ready;
      if (del) front = exp_q.pop_front();
      if (acc) exp_q.push_back(ref_model(dat, sel, hi0, hi1, lo0, lo1, cin));
      if (cnt_clr) model_cnt = 0;
      else if (del && front[0] && model_cnt < CNT_MAX) model_cnt++;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      #1;
      if (out_valid && exp_q.size() != 0) begin
        checks++;
        if (obs !== exp_q[0]) begin
          fails++; $display("FAIL rnd_drain_data: got %b want %b", obs, exp_q[0]);
        end
        front = exp_q.pop_front();
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rnd_drain: got pending=%0d valid=%b want pending=0 valid=0",
                        exp_q.size(), out_valid);
    end
  endtask

  task automatic test_stats();
    int   nacc;
    int   ndel;
    logic rdy;
    logic [CNT_W-1:0] exp_cnt;
    @(negedge clk);
    cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (hit_cnt !== '0) begin
      fails++; $display("FAIL stats_clear_idle: got %0d want 0", hit_cnt);
    end
    hi0 = 1'b1; hi1 = 1'b0; lo0 = 1'b0; lo1 = 1'b1;
    dat = '1; sel = '0; cin = 1'b0;
    nacc = 0;
    ndel = 0;
    for (int cyc = 0; cyc < 20 && ndel < 5; cyc++) begin
      @(negedge clk);
      in_valid = (nacc < 5); out_ready = 1'b1;
      #1;
      rdy = in_valid && in_ready;
      if (out_valid) ndel++;
      @(posedge clk);
      if (rdy) nacc++;
    end
    checks++;
    if (ndel !== 5) begin
      fails++; $display("FAIL stats_deliveries: got %0d want 5", ndel);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt = STATS ? CNT_W'(CNT_MAX) : '0;
    checks++;
    if (hit_cnt !== exp_cnt) begin
      fails++; $display("FAIL stats_saturate: got %0d want %0d", hit_cnt, exp_cnt);
    end
    // One more all-hit beat, cleared in the very cycle it is delivered
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL stats_clr_wait: got valid=%b want 1", out_valid);
    end
    cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (hit_cnt !== '0) begin
      fails++; $display("FAIL stats_clr_wins: got %0d want 0", hit_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [CNT_W-1:0] exp_cnt;
    hi0 = 1'b1; hi1 = 1'b0; lo0 = 1'b0; lo1 = 1'b1;
    dat = '1; sel = '0; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL ar_full: got valid=%b ready=%b want valid=1 ready=0",
                        out_valid, in_ready);
    end
    exp_cnt = STATS ? CNT_W'(1) : '0;
    checks++;
    if (hit_cnt !== exp_cnt) begin
      fails++; $display("FAIL ar_cnt_before: got %0d want %0d", hit_cnt, exp_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || hit_cnt !== '0 || obs !== '0) begin
      fails++; $display("FAIL ar_immediate: got valid=%b cnt=%0d res=%b want 0 0 0",
                        out_valid, hit_cnt, obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL ar_after: got ready=%b valid=%b want ready=1 valid=0",
                        in_ready, out_valid);
    end
    exp_q.delete();
    model_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_stats();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
